// File: rtl/i2c_slave_if.sv
// i2c_slave_if
// Host-side byte interface of the I2C slave. The I2C pins themselves (SCL, SDA)
// stay plain ports on the slave because SDA is an open-drain tri-state net.
//   tx_data  : byte returned to the bus master on read transfers
//   tx_req   : one-clk pulse, tx_data has just been latched
//   rx_data  : last byte written by the bus master
//   rx_valid : one-clk pulse, rx_data updated
//   busy     : slave is addressed (address match until STOP / foreign address)
interface i2c_slave_if;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  modport slave (
    input  tx_data,
    output tx_req,
    output rx_data,
    output rx_valid,
    output busy
  );

  modport master (
    output tx_data,
    input  tx_req,
    input  rx_data,
    input  rx_valid,
    input  busy
  );
endinterface

// File: rtl/i2c_slave.sv
// i2c_slave
// 7-bit address I2C slave clocked by the system clock. SCL and SDA are
// oversampled through 2-FF synchronizers and all bus events are edges of the
// synchronized levels, so the slave reacts 2-3 clk after the bus.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   SCL  : bus clock input (never driven)
//   SDA  : bus data, driven 1'b0 or released to 1'bz only
//   host : i2c_slave_if.slave (tx_data, tx_req, rx_data, rx_valid, busy)
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCL,
  inout  wire         SDA,
  i2c_slave_if.slave  host
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] WRITE     = 3'd3;
  localparam logic [2:0] WRITE_ACK = 3'd4;
  localparam logic [2:0] READ      = 3'd5;
  localparam logic [2:0] READ_ACK  = 3'd6;
  localparam logic [2:0] IGNORE    = 3'd7;

  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic [2:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic       rw;
  logic       master_nack;
  logic       sda_low;
  logic [7:0] rx_data_r;
  logic       rx_valid_r;
  logic       tx_req_r;
  logic       busy_r;

  logic       scl_rise, scl_fall;
  logic       start_cond, stop_cond;
  logic [7:0] shift_in;

  // Synchronizers reset to 1 so an idle bus produces no spurious edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= SCL;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= SDA;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise = scl_s2 & ~scl_d;
  assign scl_fall = ~scl_s2 & scl_d;
  // Checked against the already updated SCL level, so a simultaneous SCL rise
  // and SDA change is handled as the bit edge first and then as START/STOP.
  assign start_cond = scl_s2 & sda_d & ~sda_s2;
  assign stop_cond  = scl_s2 & ~sda_d & sda_s2;
  assign shift_in   = {shift[6:0], sda_s2};

  // Protocol FSM. The START/STOP branch at the end overrides anything the
  // per-state logic decided in the same clk, which discards partial bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      shift       <= 8'h00;
      rw          <= 1'b0;
      master_nack <= 1'b0;
      sda_low     <= 1'b0;
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      tx_req_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      tx_req_r   <= 1'b0;

      case (state)
        ADDR: begin
          if (scl_rise) begin
            shift <= shift_in;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
              if (shift[6:0] == SLAVE_ADDR) begin
                state  <= ADDR_ACK;
                busy_r <= 1'b1;
                rw     <= sda_s2;
              end else begin
                state  <= IGNORE;
                busy_r <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

        // bit_cnt 0: waiting for the fall after the 8th bit to pull SDA low;
        // bit_cnt 1: ACK is on the bus, released on the fall after the 9th bit.
        ADDR_ACK, WRITE_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              sda_low <= 1'b1;
              bit_cnt <= 4'd1;
            end else begin
              bit_cnt <= 4'd0;
              if (state == WRITE_ACK || !rw) begin
                state   <= WRITE;
                sda_low <= 1'b0;
              end else begin
                state    <= READ;
                shift    <= host.tx_data;
                tx_req_r <= 1'b1;
                sda_low  <= ~host.tx_data[7];
              end
            end
          end
        end

        WRITE: begin
          if (scl_rise) begin
            shift <= shift_in;
            if (bit_cnt == 4'd7) begin
              rx_data_r  <= shift_in;
              rx_valid_r <= 1'b1;
              state      <= WRITE_ACK;
              bit_cnt    <= 4'd0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

        // bit_cnt counts bits the master has clocked in; the MSB of shift is
        // always the bit currently on the bus.
        READ: begin
          if (scl_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_low <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= READ_ACK;
            end else begin
              shift   <= {shift[6:0], 1'b0};
              sda_low <= ~shift[6];
            end
          end
        end

        READ_ACK: begin
          if (scl_rise) begin
            master_nack <= sda_s2;
          end else if (scl_fall) begin
            if (!master_nack) begin
              state    <= READ;
              shift    <= host.tx_data;
              tx_req_r <= 1'b1;
              sda_low  <= ~host.tx_data[7];
            end else begin
              state   <= IGNORE;
              sda_low <= 1'b0;
            end
          end
        end

        IDLE, IGNORE: begin
          sda_low <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          sda_low <= 1'b0;
        end
      endcase

      if (start_cond) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_low <= 1'b0;
      end else if (stop_cond) begin
        state   <= IDLE;
        bit_cnt <= 4'd0;
        sda_low <= 1'b0;
        busy_r  <= 1'b0;
      end
    end
  end

  assign SDA = sda_low ? 1'b0 : 1'bz;

  assign host.tx_req   = tx_req_r;
  assign host.rx_data  = rx_data_r;
  assign host.rx_valid = rx_valid_r;
  assign host.busy     = busy_r;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave
// Bus-master model driving an i2c_slave (address 0x50) through write, read,
// repeated-START, aborted-byte and mid-transfer reset scenarios. Written bytes
// and returned read bytes are tracked in scoreboard queues.
module tb_i2c_slave;

  localparam int Q = 100;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       exp_ack;
  } wr_vec_t;

  logic clk;
  logic rst;
  logic scl;
  logic m_low;
  wire  sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave_if host_bus ();

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk  (clk),
    .rst  (rst),
    .SCL  (scl),
    .SDA  (sda),
    .host (host_bus)
  );

  int vectors;
  int miscompares;
  int rx_pulses;
  int tx_pulses;
  int drive_cnt;
  int wide_cnt;
  int overlap_cnt;
  logic rx_prev;
  logic tx_prev;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_exp;
  wr_vec_t vecs [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  // Pulse monitor and rx scoreboard consumer.
  always @(negedge clk) begin
    if (host_bus.rx_valid === 1'b1) begin
      rx_pulses++;
      checkOutput("rx_expected", 32'(rx_q.size() > 0), 32'd1);
      if (rx_q.size() > 0) begin
        rx_exp = rx_q.pop_front();
        checkOutput("rx_data", 32'(host_bus.rx_data), 32'(rx_exp));
      end
    end
    if (host_bus.tx_req === 1'b1) tx_pulses++;
    if (host_bus.rx_valid === 1'b1 && rx_prev === 1'b1) wide_cnt++;
    if (host_bus.tx_req === 1'b1 && tx_prev === 1'b1) wide_cnt++;
    if (host_bus.rx_valid === 1'b1 && host_bus.tx_req === 1'b1) overlap_cnt++;
    if (m_low === 1'b0 && sda === 1'b0) drive_cnt++;
    rx_prev = host_bus.rx_valid;
    tx_prev = host_bus.tx_req;
  end

  task automatic bus_start();
    #Q m_low = 1'b0;
    #Q scl = 1'b1;
    #(2*Q) m_low = 1'b1;
    #(2*Q) scl = 1'b0;
  endtask

  task automatic bus_stop();
    #Q m_low = 1'b1;
    #Q scl = 1'b1;
    #(2*Q) m_low = 1'b0;
    #(2*Q);
  endtask

  task automatic send_bit(input logic b);
    #Q m_low = ~b;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] data, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(data[i]);
    #Q m_low = 1'b0;
    #Q scl = 1'b1;
    #Q ack = (sda === 1'b0);
    #Q scl = 1'b0;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] data);
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #(2*Q) scl = 1'b1;
      #Q data[i] = (sda === 1'b1);
      #Q scl = 1'b0;
    end
    #Q m_low = mack;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
  endtask

  // One complete START / address / data / STOP write transaction.
  task automatic applyStimulus(input wr_vec_t v);
    logic ack;
    int   r0;
    int   d0;
    r0 = rx_pulses;
    d0 = drive_cnt;
    bus_start();
    write_byte(v.addr, ack);
    checkOutput("addr_ack", 32'(ack), 32'(v.exp_ack));
    checkOutput("busy_after_addr", 32'(host_bus.busy), 32'(v.exp_ack));
    if (v.exp_ack) rx_q.push_back(v.data);
    write_byte(v.data, ack);
    checkOutput("data_ack", 32'(ack), 32'(v.exp_ack));
    bus_stop();
    checkOutput("busy_after_stop", 32'(host_bus.busy), 32'd0);
    checkOutput("rx_pulse_count", rx_pulses - r0, v.exp_ack ? 32'd1 : 32'd0);
    if (!v.exp_ack) checkOutput("sda_drive_count", drive_cnt - d0, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_sda"}, 32'(sda === 1'b1), 32'd1);
    checkOutput({tag, "_rx_data"}, 32'(host_bus.rx_data), 32'h00);
    checkOutput({tag, "_rx_valid"}, 32'(host_bus.rx_valid), 32'd0);
    checkOutput({tag, "_tx_req"}, 32'(host_bus.tx_req), 32'd0);
    checkOutput({tag, "_busy"}, 32'(host_bus.busy), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: time limit reached, actual running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int         t0;
    int         r0;

    vectors = 0; miscompares = 0;
    rx_pulses = 0; tx_pulses = 0; drive_cnt = 0; wide_cnt = 0; overlap_cnt = 0;
    rx_prev = 1'b0; tx_prev = 1'b0;
    scl = 1'b1; m_low = 1'b0; host_bus.tx_data = 8'h00;
    rst = 1'b0;

    vecs[0] = '{addr: 8'hA0, data: 8'h3C, exp_ack: 1'b1};
    vecs[1] = '{addr: 8'hA2, data: 8'hFF, exp_ack: 1'b0};
    vecs[2] = '{addr: 8'hA0, data: 8'h00, exp_ack: 1'b1};
    vecs[3] = '{addr: 8'hA0, data: 8'hFF, exp_ack: 1'b1};
    vecs[4] = '{addr: 8'h20, data: 8'h55, exp_ack: 1'b0};
    vecs[5] = '{addr: 8'hA0, data: 8'h81, exp_ack: 1'b1};
    vecs[6] = '{addr: 8'hA4, data: 8'hAA, exp_ack: 1'b0};
    vecs[7] = '{addr: 8'hA0, data: 8'hA5, exp_ack: 1'b1};

    #3 rst = 1'b1;
    #40;
    check_reset_outputs("reset");
    rst = 1'b0;
    #100;

    $display("[TB] write vector table");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
    checkOutput("rx_data_last", 32'(host_bus.rx_data), 32'hA5);

    $display("[TB] read with ACK then NACK");
    host_bus.tx_data = 8'h96;
    t0 = tx_pulses;
    bus_start();
    write_byte(8'hA1, ack);
    checkOutput("read_addr_ack", 32'(ack), 32'd1);
    #Q;
    checkOutput("tx_req_first", tx_pulses - t0, 32'd1);
    tx_q.push_back(8'h96);
    host_bus.tx_data = 8'h5A;
    tx_q.push_back(8'h5A);
    read_byte(1'b1, d);
    checkOutput("read_byte0", 32'(d), 32'(tx_q.pop_front()));
    read_byte(1'b0, d);
    checkOutput("read_byte1", 32'(d), 32'(tx_q.pop_front()));
    #Q;
    checkOutput("tx_req_count", tx_pulses - t0, 32'd2);
    checkOutput("sda_after_nack", 32'(sda === 1'b1), 32'd1);
    checkOutput("busy_before_stop", 32'(host_bus.busy), 32'd1);
    bus_stop();
    checkOutput("busy_read_stop", 32'(host_bus.busy), 32'd0);

    $display("[TB] write then repeated START read");
    r0 = rx_pulses;
    bus_start();
    write_byte(8'hA0, ack);
    checkOutput("rs_addr_ack", 32'(ack), 32'd1);
    rx_q.push_back(8'h11);
    write_byte(8'h11, ack);
    checkOutput("rs_data_ack", 32'(ack), 32'd1);
    host_bus.tx_data = 8'h33;
    bus_start();
    checkOutput("busy_rep_start", 32'(host_bus.busy), 32'd1);
    t0 = tx_pulses;
    write_byte(8'hA1, ack);
    checkOutput("rs_read_addr_ack", 32'(ack), 32'd1);
    #Q;
    checkOutput("rs_tx_req", tx_pulses - t0, 32'd1);
    tx_q.push_back(8'h33);
    read_byte(1'b0, d);
    checkOutput("rs_read_byte", 32'(d), 32'(tx_q.pop_front()));
    bus_stop();
    checkOutput("rs_rx_data", 32'(host_bus.rx_data), 32'h11);
    checkOutput("rs_rx_pulses", rx_pulses - r0, 32'd1);
    checkOutput("rs_busy_stop", 32'(host_bus.busy), 32'd0);

    $display("[TB] STOP after four data bits");
    r0 = rx_pulses;
    bus_start();
    write_byte(8'hA0, ack);
    checkOutput("abort_addr_ack", 32'(ack), 32'd1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    bus_stop();
    checkOutput("abort_rx_pulses", rx_pulses - r0, 32'd0);
    checkOutput("abort_busy", 32'(host_bus.busy), 32'd0);
    checkOutput("abort_sda", 32'(sda === 1'b1), 32'd1);
    applyStimulus('{addr: 8'hA0, data: 8'h42, exp_ack: 1'b1});
    checkOutput("abort_next_rx", 32'(host_bus.rx_data), 32'h42);

    $display("[TB] reset during READ");
    host_bus.tx_data = 8'h00;
    bus_start();
    write_byte(8'hA1, ack);
    checkOutput("rstrd_addr_ack", 32'(ack), 32'd1);
    #Q;
    checkOutput("rstrd_sda_driven", 32'(sda === 1'b0), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rstrd");
    #29 rst = 1'b0;
    #Q scl = 1'b1;
    #(2*Q);
    applyStimulus('{addr: 8'hA0, data: 8'h77, exp_ack: 1'b1});

    #(4*Q);
    checkOutput("pulse_width_violations", wide_cnt, 32'd0);
    checkOutput("pulse_overlap", overlap_cnt, 32'd0);
    checkOutput("rx_queue_left", 32'(rx_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
